// File: rtl/cnt_core.sv
// Counter datapath: prescaled tick, one-shot / auto-reload terminal count, IDLE/RUN/DONE run-state FSM.
// Optional prescaler selected by `define CNT_CORE_PRESCALER_EN (otherwise tick every RUN cycle).
module cnt_core #(
  parameter int W       = 32,
  parameter int PRESC_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cnt_en_i,
  input  logic               cnt_clr_i,
  input  logic [W-1:0]       cnt_thr_i,
  input  logic               mode_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [W-1:0]       cnt_val_o,
  output logic               cnt_tc_o,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       run;
  logic       tick;
  logic       terminal;

  assign run      = (state == S_RUN) && cnt_en_i;
  assign terminal = (cnt_val_o >= cnt_thr_i);

`ifdef CNT_CORE_PRESCALER_EN
  logic [PRESC_W-1:0] presc_q;

  // >= rather than == so a divisor lowered below the running prescaler wraps at once
  assign tick = run && (presc_q >= presc_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      presc_q <= '0;
    end else if (run) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end
`else
  logic unused_presc;
  assign unused_presc = ^presc_i;
  assign tick         = run;
`endif

  always_comb begin
    state_nxt = state;
    if (cnt_clr_i) begin
      state_nxt = cnt_en_i ? S_RUN : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cnt_en_i) state_nxt = S_RUN;
        S_RUN: begin
          if (!cnt_en_i)                         state_nxt = S_IDLE;
          else if (tick && terminal && !mode_i)  state_nxt = S_DONE;
        end
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      cnt_val_o <= '0;
      cnt_tc_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt == S_RUN);
      if (cnt_clr_i) begin
        cnt_val_o <= '0;
        cnt_tc_o  <= 1'b0;
      end else begin
        cnt_tc_o <= tick && terminal;
        // one-shot terminal holds the value; reload only in auto-reload mode
        if (tick) begin
          if (!terminal)   cnt_val_o <= cnt_val_o + 1'b1;
          else if (mode_i) cnt_val_o <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnt_core.sv
// Directed bench for cnt_core: cycle table plus prescaler, threshold-lowering and reset sequences.
module tb_cnt_core;

  localparam int W       = 32;
  localparam int PRESC_W = 8;
`ifdef CNT_CORE_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic               clk = 1'b0;
  logic               rst, en, clr, mode;
  logic [W-1:0]       thr;
  logic [PRESC_W-1:0] presc;
  logic [W-1:0]       val;
  logic               tc, busy;

  int n_tests = 0;
  int n_fail  = 0;

  cnt_core #(.W(W), .PRESC_W(PRESC_W)) dut (
    .clk_i(clk), .rst_i(rst), .cnt_en_i(en), .cnt_clr_i(clr),
    .cnt_thr_i(thr), .mode_i(mode), .presc_i(presc),
    .cnt_val_o(val), .cnt_tc_o(tc), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, clr, mode;
    logic [W-1:0] thr;
    logic [W-1:0] exp_val;
    logic       exp_tc, exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic c, input logic m,
                     input int t, input int ev, input logic etc, input logic eb);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.mode = m; v.thr = W'(t);
    v.exp_val = W'(ev); v.exp_tc = etc; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int ev, input logic etc, input logic eb);
    check({name, ".val"},  val,         W'(ev));
    check({name, ".tc"},   W'(tc),      W'(etc));
    check({name, ".busy"}, W'(busy),    W'(eb));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b1; thr = '0; presc = '0;

    //   rst en clr mode thr  val tc busy
    add(1, 0, 0, 1, 5,   0, 0, 0);  // reset
    add(0, 1, 0, 1, 5,   0, 0, 1);  // IDLE->RUN
    add(0, 1, 0, 1, 5,   1, 0, 1);
    add(0, 1, 0, 1, 5,   2, 0, 1);
    add(0, 1, 0, 1, 5,   3, 0, 1);
    add(0, 1, 0, 1, 5,   4, 0, 1);
    add(0, 1, 0, 1, 5,   5, 0, 1);
    add(0, 1, 0, 1, 5,   0, 1, 1);  // auto-reload terminal
    add(0, 1, 0, 1, 5,   1, 0, 1);
    add(0, 1, 0, 1, 5,   2, 0, 1);
    add(0, 1, 0, 1, 1,   0, 1, 1);  // thr lowered below value
    add(0, 1, 0, 1, 1,   1, 0, 1);
    add(0, 1, 0, 1, 1,   0, 1, 1);
    add(0, 1, 0, 1, 0,   0, 1, 1);  // thr=0: tc every cycle
    add(0, 1, 0, 1, 0,   0, 1, 1);
    add(0, 0, 0, 1, 0,   0, 0, 0);  // pause
    add(0, 0, 0, 1, 0,   0, 0, 0);
    add(0, 0, 1, 0, 3,   0, 0, 0);  // clr, en low -> IDLE
    add(0, 1, 0, 0, 3,   0, 0, 1);  // one-shot
    add(0, 1, 0, 0, 3,   1, 0, 1);
    add(0, 1, 0, 0, 3,   2, 0, 1);
    add(0, 1, 0, 0, 3,   3, 0, 1);
    add(0, 1, 0, 0, 3,   3, 1, 0);  // DONE
    add(0, 1, 0, 0, 3,   3, 0, 0);
    add(0, 0, 0, 0, 3,   3, 0, 0);
    add(0, 1, 0, 0, 3,   3, 0, 0);
    add(0, 1, 1, 0, 3,   0, 0, 1);  // clr with en -> RUN
    add(0, 1, 0, 0, 3,   1, 0, 1);
    add(0, 0, 1, 0, 3,   0, 0, 0);
    add(0, 0, 0, 0, 3,   0, 0, 0);
    add(0, 1, 0, 0, 3,   0, 0, 1);
    add(0, 1, 0, 0, 3,   1, 0, 1);
    add(0, 0, 0, 0, 3,   1, 0, 0);  // pause holds value
    add(0, 0, 0, 0, 3,   1, 0, 0);
    add(0, 1, 0, 0, 3,   1, 0, 1);
    add(0, 1, 0, 0, 3,   2, 0, 1);
    add(0, 1, 1, 1, 2,   0, 0, 1);  // clr beats terminal tick
    add(0, 1, 0, 1, 2,   1, 0, 1);
    add(1, 1, 1, 1, 2,   0, 0, 0);  // rst beats clr
    add(0, 1, 0, 1, 2,   0, 0, 1);
    add(0, 1, 0, 1, 2,   1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; clr = vecs[i].clr;
      mode = vecs[i].mode; thr = vecs[i].thr; presc = '0;
      step();
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_val), vecs[i].exp_tc, vecs[i].exp_busy);
    end

    // prescaler 3, thr 2, auto-reload
    rst = 1'b1; clr = 1'b0; step();
    rst = 1'b0; en = 1'b1; mode = 1'b1; thr = 2; presc = 3; step();
    check_all("presc.start", 0, 1'b0, 1'b1);
    for (int k = 1; k <= 24; k++) begin
      int ticks;
      step();
      ticks = k / P;
      check_all($sformatf("presc.k%0d", k), ticks % 3,
                (k % P == 0) && (ticks % 3 == 0), 1'b1);
    end

`ifdef CNT_CORE_PRESCALER_EN
    // divisor lowered below the running prescaler value
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; thr = 20; presc = 7; step();
    for (int k = 0; k < 5; k++) step();
    check("plow.before", val, 0);
    presc = 2; step();
    check("plow.wrap", val, 1);
    step(); step();
    check("plow.hold", val, 1);
    step();
    check("plow.next", val, 2);
`endif

    // threshold lowered from 20 to 4 at value 10
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; mode = 1'b1; thr = 20; presc = 0; step();
    for (int k = 0; k < 10; k++) step();
    check_all("thr.at10", 10, 1'b0, 1'b1);
    thr = 4; step();
    check_all("thr.term", 0, 1'b1, 1'b1);
    step();
    check_all("thr.after", 1, 1'b0, 1'b1);

    // reset mid-count
    rst = 1'b1; step();
    rst = 1'b0; en = 1'b1; thr = 20; presc = 3; step();
    begin
      int guard = 0;
      while (val != 7 && guard < 100) begin
        step();
        guard++;
      end
      check("rst.reach7", val, 7);
    end
`ifdef CNT_CORE_PRESCALER_EN
    step();
`endif
    rst = 1'b1; step();
    check_all("rst.mid", 0, 1'b0, 1'b0);
    rst = 1'b0; step();
    check_all("rst.rerun", 0, 1'b0, 1'b1);
    for (int k = 0; k < P - 1; k++) step();
    check("rst.hold0", val, 0);
    step();
    check("rst.first", val, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
